fpu_dp_adder: RTL and testbench

IEEE-754 binary64 (double-precision) floating-point adder/subtractor with registered outputs.
- Adds two 64-bit operands and produces a 64-bit sum, rounded to nearest-even.
- Raises a single combined overflow/underflow flag.
- Serves as the double-precision add unit of the FPU; subtraction is done upstream by flipping the sign of b.

---
 rtl/fpu_dp_pkg.sv | 34 +++
 rtl/fpu_dp_lzc.sv | 20 ++
 rtl/fpu_dp_adder.sv | 162 ++++++++++++++++
 tb/tb_fpu_dp_adder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_dp_pkg.sv
// Shared constants, the binary64 field layout and small classification
// helpers for the double-precision adder.
package fpu_dp_pkg;

    localparam int EXP_W   = 11;
    localparam int FRAC_W  = 52;
    localparam int BIAS    = 1023;
    localparam int EXP_MAX = 2047;

    localparam logic [63:0] QNAN    = 64'h7FF8_0000_0000_0000;
    localparam logic [63:0] POS_INF = 64'h7FF0_0000_0000_0000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp64_t;

    // All-ones exponent with a nonzero fraction.
    function automatic logic is_nan(input fp64_t x);
        return (x.exp == 11'h7FF) && (x.frac != 52'd0);
    endfunction

    // All-ones exponent with a zero fraction.
    function automatic logic is_inf(input fp64_t x);
        return (x.exp == 11'h7FF) && (x.frac == 52'd0);
    endfunction

    // Zero exponent: true zeros and denormals, which are flushed to zero.
    function automatic logic is_zero(input fp64_t x);
        return (x.exp == 11'd0);
    endfunction

endpackage

// File: rtl/fpu_dp_lzc.sv
// 57-bit leading-zero counter used to normalise the raw significand sum.
// An all-zero input reports 57.
module fpu_dp_lzc (
    input  logic [56:0] data,
    output logic [5:0]  count
);

    // Scan from the LSB upward so the highest set bit is written last and wins.
    always_comb begin
        count = 6'd57;
        for (int i = 0; i < 57; i++) begin
            if (data[i]) begin
                count = 6'(56 - i);
            end else begin
                count = count;
            end
        end
    end

endmodule

// File: rtl/fpu_dp_adder.sv
// IEEE-754 binary64 adder, round to nearest-even, flush-to-zero on denormal
// inputs and on underflowing results. Combinational datapath, one register
// stage on the outputs (latency 1, throughput 1 per cycle).
module fpu_dp_adder
    import fpu_dp_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             overflow_underflow_flag
);

    localparam logic signed [12:0] EXP_LIMIT = 13'(EXP_MAX);

    fp64_t              op_a_s;
    fp64_t              op_b_s;
    logic               a_big_s;
    logic               s_big_s;
    logic [10:0]        e_big_s;
    logic [10:0]        e_sml_s;
    logic [10:0]        diff_s;
    logic [51:0]        f_big_s;
    logic [51:0]        f_sml_s;
    logic [56:0]        mant_big_s;
    logic [56:0]        mant_sml_s;
    logic [56:0]        aligned_s;
    logic [56:0]        sum_s;
    logic               lost_s;
    logic               eff_sub_s;
    logic [5:0]         lz_s;
    logic [5:0]         sh_s;
    logic [55:0]        norm_s;
    logic signed [12:0] exp_norm_s;
    logic signed [12:0] exp_fin_s;
    logic               round_up_s;
    logic [53:0]        rounded_s;
    logic [51:0]        frac_fin_s;
    logic [63:0]        res_s;
    logic               flag_s;

    assign op_a_s = fp64_t'(a);
    assign op_b_s = fp64_t'(b);

    // Order operands by magnitude, align the smaller one with a sticky bit,
    // then add or subtract significands in a carry + 53 + G/R/S layout.
    always_comb begin
        a_big_s    = ({op_a_s.exp, op_a_s.frac} >= {op_b_s.exp, op_b_s.frac});
        s_big_s    = 1'b0;
        e_big_s    = 11'd0;
        f_big_s    = 52'd0;
        e_sml_s    = 11'd0;
        f_sml_s    = 52'd0;
        aligned_s  = 57'd0;
        lost_s     = 1'b0;
        if (a_big_s) begin
            s_big_s = op_a_s.sign;
            e_big_s = op_a_s.exp;
            f_big_s = op_a_s.frac;
            e_sml_s = op_b_s.exp;
            f_sml_s = op_b_s.frac;
        end else begin
            s_big_s = op_b_s.sign;
            e_big_s = op_b_s.exp;
            f_big_s = op_b_s.frac;
            e_sml_s = op_a_s.exp;
            f_sml_s = op_a_s.frac;
        end
        diff_s     = e_big_s - e_sml_s;
        mant_big_s = {1'b0, 1'b1, f_big_s, 3'b000};
        mant_sml_s = {1'b0, 1'b1, f_sml_s, 3'b000};
        // Past 55 positions even the hidden bit has left; only sticky remains.
        if (diff_s >= 11'd56) begin
            aligned_s = 57'd1;
        end else begin
            lost_s    = |(mant_sml_s & ~({57{1'b1}} << diff_s));
            aligned_s = (mant_sml_s >> diff_s) | {56'd0, lost_s};
        end
        eff_sub_s = op_a_s.sign ^ op_b_s.sign;
        if (eff_sub_s) begin
            sum_s = mant_big_s - aligned_s;
        end else begin
            sum_s = mant_big_s + aligned_s;
        end
    end

    fpu_dp_lzc u_lzc (
        .data  (sum_s),
        .count (lz_s)
    );

    // Normalise, round to nearest-even, detect range errors and select
    // the special-value / zero / finite result.
    always_comb begin
        sh_s = lz_s - 6'd1;
        if (sum_s[56]) begin
            norm_s     = {sum_s[56:2], sum_s[1] | sum_s[0]};
            exp_norm_s = $signed({2'b00, e_big_s}) + 13'sd1;
        end else begin
            norm_s     = sum_s[55:0] << sh_s;
            exp_norm_s = $signed({2'b00, e_big_s}) - $signed({7'd0, sh_s});
        end
        // Guard set and (sticky or odd LSB) rounds up; an exact tie stays even.
        round_up_s = norm_s[2] & ((|norm_s[1:0]) | norm_s[3]);
        rounded_s  = {1'b0, norm_s[55:3]} + {53'd0, round_up_s};
        if (rounded_s[53]) begin
            exp_fin_s  = exp_norm_s + 13'sd1;
            frac_fin_s = rounded_s[52:1];
        end else begin
            exp_fin_s  = exp_norm_s;
            frac_fin_s = rounded_s[51:0];
        end

        res_s  = 64'd0;
        flag_s = 1'b0;
        if (is_nan(op_a_s) || is_nan(op_b_s)) begin
            res_s = QNAN;
        end else if (is_inf(op_a_s) && is_inf(op_b_s)) begin
            if (op_a_s.sign != op_b_s.sign) begin
                res_s = QNAN;
            end else begin
                res_s = a;
            end
        end else if (is_inf(op_a_s)) begin
            res_s = a;
        end else if (is_inf(op_b_s)) begin
            res_s = b;
        end else if (is_zero(op_a_s) && is_zero(op_b_s)) begin
            res_s = {op_a_s.sign & op_b_s.sign, 63'd0};
        end else if (is_zero(op_a_s)) begin
            res_s = b;
        end else if (is_zero(op_b_s)) begin
            res_s = a;
        end else if (sum_s == 57'd0) begin
            // Exact cancellation is +0 and is not an underflow.
            res_s = 64'd0;
        end else if (exp_fin_s >= EXP_LIMIT) begin
            res_s  = {s_big_s, POS_INF[62:0]};
            flag_s = 1'b1;
        end else if (exp_fin_s <= 13'sd0) begin
            res_s  = {s_big_s, 63'd0};
            flag_s = 1'b1;
        end else begin
            res_s = {s_big_s, exp_fin_s[10:0], frac_fin_s};
        end
    end

    // Output register; asynchronous reset clears the sum and the flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result                  <= 64'd0;
            overflow_underflow_flag <= 1'b0;
        end else begin
            result                  <= res_s;
            overflow_underflow_flag <= flag_s;
        end
    end

endmodule

// File: tb/tb_fpu_dp_adder.sv
// Bench for fpu_dp_adder: directed vector table, reset sequences and a
// randomized back-to-back stream against a host-real reference model.
module tb_fpu_dp_adder;

    localparam logic [63:0] QNAN_C = 64'h7FF8_0000_0000_0000;
    localparam logic [63:0] PINF_C = 64'h7FF0_0000_0000_0000;
    localparam logic [63:0] NINF_C = 64'hFFF0_0000_0000_0000;
    localparam int          NV     = 20;
    localparam int          NR     = 600;

    logic        clk;
    logic        rst;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] result;
    logic        overflow_underflow_flag;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [63:0] res;
        logic        flag;
    } ref_t;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] r;
        logic        f;
    } vec_t;

    vec_t vecs [NV];
    ref_t exp_q [$];

    fpu_dp_adder #(.WIDTH(64)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .a                       (a),
        .b                       (b),
        .result                  (result),
        .overflow_underflow_flag (overflow_underflow_flag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    function automatic logic f_nan(input logic [63:0] x);
        return (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
    endfunction

    function automatic logic f_inf(input logic [63:0] x);
        return (x[62:52] == 11'h7FF) && (x[51:0] == 52'd0);
    endfunction

    // Reference: specials by rule, everything finite via host double addition,
    // then map host infinities/denormals onto overflow/flush-to-zero.
    function automatic ref_t ref_add(input logic [63:0] x, input logic [63:0] y);
        logic [63:0] xf;
        logic [63:0] yf;
        logic [63:0] s;
        real         r;
        ref_t        o;
        xf = (x[62:52] == 11'd0) ? {x[63], 63'd0} : x;
        yf = (y[62:52] == 11'd0) ? {y[63], 63'd0} : y;
        o.flag = 1'b0;
        o.res  = 64'd0;
        if (f_nan(x) || f_nan(y)) begin
            o.res = QNAN_C;
        end else if (f_inf(x) && f_inf(y)) begin
            o.res = (x[63] != y[63]) ? QNAN_C : x;
        end else if (f_inf(x)) begin
            o.res = x;
        end else if (f_inf(y)) begin
            o.res = y;
        end else begin
            r = $bitstoreal(xf) + $bitstoreal(yf);
            s = $realtobits(r);
            if (s[62:52] == 11'h7FF) begin
                o.res  = s;
                o.flag = 1'b1;
            end else if ((s[62:52] == 11'd0) && (s[51:0] != 52'd0)) begin
                o.res  = {s[63], 63'd0};
                o.flag = 1'b1;
            end else begin
                o.res = s;
            end
        end
        return o;
    endfunction

    function automatic logic [63:0] rand_op(input int center, input int spread);
        int          k;
        int          ei;
        logic        sg;
        logic [51:0] f;
        k  = int'($urandom_range(0, 99));
        sg = 1'($urandom_range(0, 1));
        f  = 52'({$urandom(), $urandom()});
        ei = center + int'($urandom_range(0, 2 * spread)) - spread;
        if (ei < 1) ei = 1;
        if (ei > 2046) ei = 2046;
        if (k < 3) return {sg, 11'h7FF, f | 52'd1};
        if (k < 6) return {sg, 11'h7FF, 52'd0};
        if (k < 9) return {sg, 63'd0};
        if (k < 12) return {sg, 11'd0, f};
        return {sg, 11'(ei), f};
    endfunction

    task automatic gen_pair(output logic [63:0] x, output logic [63:0] y);
        int c;
        int sp;
        int m;
        m = int'($urandom_range(0, 3));
        c = (m == 0) ? 1023 : (m == 1) ? 2044 : (m == 2) ? 4 : 600;
        sp = ($urandom_range(0, 3) == 0) ? 60 : 4;
        x = rand_op(c, sp);
        y = rand_op(c, sp);
        // Near-cancellation: negate x and disturb a few low fraction bits.
        if ($urandom_range(0, 4) == 0) begin
            y = {~x[63], x[62:0] ^ 63'($urandom_range(0, 15))};
        end
    endtask

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        ref_t        e;

        vecs[0]  = '{$realtobits(4.20), $realtobits(3.20), $realtobits(4.20 + 3.20), 1'b0};
        vecs[1]  = '{$realtobits(6.40), $realtobits(-0.50), $realtobits(6.40 + (-0.50)), 1'b0};
        vecs[2]  = '{$realtobits(2234.0132), $realtobits(-1235.3412),
                     $realtobits(2234.0132 + (-1235.3412)), 1'b0};
        vecs[3]  = '{$realtobits(124054.4312345), $realtobits(-9213743.123655343),
                     $realtobits(124054.4312345 + (-9213743.123655343)), 1'b0};
        vecs[4]  = '{$realtobits(121.3232), $realtobits(-123.1231),
                     $realtobits(121.3232 + (-123.1231)), 1'b0};
        vecs[5]  = '{$realtobits(-6.40), $realtobits(-0.50), $realtobits((-6.40) + (-0.50)), 1'b0};
        vecs[6]  = '{$realtobits(0.66), $realtobits(0.51), $realtobits(0.66 + 0.51), 1'b0};
        vecs[7]  = '{$realtobits(1.5), $realtobits(-1.5), 64'h0000_0000_0000_0000, 1'b0};
        vecs[8]  = '{64'h7FEF_FFFF_FFFF_FFFF, 64'h7FEF_FFFF_FFFF_FFFF, PINF_C, 1'b1};
        vecs[9]  = '{64'h0010_0000_0000_0001, 64'h8010_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b1};
        vecs[10] = '{PINF_C, NINF_C, QNAN_C, 1'b0};
        vecs[11] = '{64'h7FF0_0000_0000_0001, $realtobits(1.0), QNAN_C, 1'b0};
        vecs[12] = '{64'h0000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b0};
        vecs[13] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0};
        vecs[14] = '{64'h0000_0000_0000_0000, $realtobits(3.0), $realtobits(3.0), 1'b0};
        vecs[15] = '{PINF_C, $realtobits(2.0), PINF_C, 1'b0};
        vecs[16] = '{NINF_C, NINF_C, NINF_C, 1'b0};
        vecs[17] = '{64'h0000_0000_0000_0005, $realtobits(1.0), $realtobits(1.0), 1'b0};
        vecs[18] = '{$realtobits(1.0), 64'h3C30_0000_0000_0000, $realtobits(1.0), 1'b0};
        vecs[19] = '{$realtobits(1.0), 64'h3CA0_0000_0000_0000, $realtobits(1.0), 1'b0};

        rst = 1'b1;
        a   = 64'd0;
        b   = 64'd0;
        repeat (2) @(negedge clk);
        check("reset_result", result, 64'd0);
        check("reset_flag", {63'd0, overflow_underflow_flag}, 64'd0);

        // Clock edges while reset is high must not load the sum.
        a = $realtobits(1.0);
        b = $realtobits(1.0);
        @(negedge clk);
        check("reset_wins_result", result, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            a = vecs[i].a;
            b = vecs[i].b;
            @(negedge clk);
            check($sformatf("vec%0d_result", i), result, vecs[i].r);
            check($sformatf("vec%0d_flag", i), {63'd0, overflow_underflow_flag}, {63'd0, vecs[i].f});
        end

        // Mid-stream asynchronous reset clears a pending overflow immediately.
        @(negedge clk);
        a = 64'h7FEF_FFFF_FFFF_FFFF;
        b = 64'h7FEF_FFFF_FFFF_FFFF;
        @(posedge clk);
        #1;
        check("pre_reset_result", result, PINF_C);
        check("pre_reset_flag", {63'd0, overflow_underflow_flag}, 64'd1);
        #1 rst = 1'b1;
        #1;
        check("async_reset_result", result, 64'd0);
        check("async_reset_flag", {63'd0, overflow_underflow_flag}, 64'd0);
        @(negedge clk);
        check("held_reset_result", result, 64'd0);
        rst = 1'b0;

        // Back-to-back random issue: each result must appear exactly one edge later.
        for (int i = 0; i < NR; i++) begin
            @(negedge clk);
            gen_pair(ra, rb);
            a = ra;
            b = rb;
            #1;
            if (i > 0) begin
                e = exp_q.pop_front();
                check($sformatf("rand%0d_result", i - 1), result, e.res);
                check($sformatf("rand%0d_flag", i - 1), {63'd0, overflow_underflow_flag}, {63'd0, e.flag});
            end
            exp_q.push_back(ref_add(ra, rb));
        end
        @(negedge clk);
        #1;
        e = exp_q.pop_front();
        check("rand_last_result", result, e.res);
        check("rand_last_flag", {63'd0, overflow_underflow_flag}, {63'd0, e.flag});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
